instr_issue_queue: RTL and testbench
====================================

// Module: instr_issue_queue
// PURPOSE
//  Consumer side of the rename->queue interface: buffers renamed instructions from register_renaming
//  (instr_wr/next_instr), tracks source-operand readiness via busy-bit snapshot plus writeback tag wakeup,
//  and issues the oldest ready entry per cycle to execute over a valid/ready handshake.
//  Collapsing queue: slot 0 = oldest. Sits between rename and execute; flushed by hazard controller on mispredict.
// PARAMETERS
//  DEPTH      16   number of queue entries (>=2)
//  TAG_W      6    physical register tag width (64 phys regs)
//  PAYLOAD_W  96   opaque bits carried unchanged (alu_ctl, imm, branch/mem fields, valid)
// PORTS
//  clk          in   1          clock
//  rst_n        in   1          async active-low reset
//  in_wr        in   1          rename presents an instruction (instr_wr)
//  in_ready     out  1          queue can accept this cycle
//  in_rs_phys   in   TAG_W      source rs tag
//  in_rt_phys   in   TAG_W      source rt tag
//  in_rw_phys   in   TAG_W      destination tag
//  in_uses_rs   in   1          rs operand used
//  in_uses_rt   in   1          rt operand used
//  in_uses_rw   in   1          destination written
//  in_payload   in   PAYLOAD_W  remaining entry fields
//  busy_bits    in   2**TAG_W   busy table snapshot, bit i=1 -> phys reg i pending
//  wb_valid     in   1          writeback broadcast valid
//  wb_tag       in   TAG_W      tag being written back
//  iss_valid    out  1          an entry is ready to issue
//  iss_ready    in   1          execute accepts
//  iss_rs_phys/iss_rt_phys/iss_rw_phys  out  TAG_W  tags of issued entry
//  iss_uses_rw  out  1          issued entry writes rw
//  iss_payload  out  PAYLOAD_W  payload of issued entry
//  flush        in   1          squash all entries (mispredict)
//  count        out  $clog2(DEPTH+1)  occupied entries
// BEHAVIOUR
//  Reset: all entry valid bits 0, count=0, in_ready=1, iss_valid=0; iss_* data outputs 0.
//  Entry state: valid, rs_rdy, rt_rdy, tags, uses_*, payload.
//  in_ready = (count < DEPTH); no credit from a same-cycle issue. in_wr && !in_ready: input ignored.
//  Insert (in_wr && in_ready && !flush): written to slot count, or count-1 if an issue fires same cycle.
//   rs_rdy = !uses_rs | (rs_phys==0) | !busy_bits[rs_phys] | (wb_valid & wb_tag==rs_phys); rt_rdy likewise.
//   Inserted entry is not issue-eligible until next cycle (1-cycle min queue latency).
//  Wakeup: each valid entry with wb_valid & wb_tag==tag sets that rdy bit at edge; issue possible next cycle.
//   Phys tag 0 is always ready; wb of tag 0 is harmless.
//  Select (combinational from registered state): lowest-index valid entry with rs_rdy & rt_rdy.
//   iss_valid=1 iff such entry exists; iss_* show it. Outputs stable while iss_valid & !iss_ready.
//  Issue (iss_valid & iss_ready): at edge selected slot removed, all higher slots shift down by one
//   preserving age order and their rdy bits (including same-edge wakeups); count decrements.
//  Simultaneous insert+issue: count unchanged; new entry lands in slot count-1 after shift.
//  Full (count==DEPTH): in_ready=0; issue still allowed; in_ready=1 next cycle after issue.
//  Empty: iss_valid=0; iss_ready ignored.
//  flush: at edge all valid bits cleared, count=0; dominates insert, issue and wakeup that cycle.
//  Async reset mid-operation discards all entries immediately.
//  count never exceeds DEPTH; no underflow (issue requires a valid entry).
// TESTING
//  1. Reset, insert rs=5 rt=6 busy=0 -> iss_valid=1 next cycle, tags 5/6, count 1->0 on iss_ready.
//  2. Insert A(rs=9 busy), then B(rs=3 ready) -> B issues first; wb_tag=9 -> A issues cycle after wb.
//  3. Fill 16 entries all busy -> in_ready=0, in_wr dropped; wb wakes slot 7 -> issues, in_ready=1 next cycle.
//  4. Same cycle: insert + issue slot 0 + wb_tag matching new entry's rs -> count unchanged, order kept, new entry ready.
//  5. iss_ready=0 held 3 cycles with ready head -> iss_* stable; flush with 5 entries -> count=0, iss_valid=0 next cycle.
//  6. Assert rst_n=0 mid-stream with count=10 -> count=0, iss_valid=0 immediately, in_ready=1.

Source files
------------

// File: rtl/instr_issue_queue.sv
// Collapsing in-order-age issue queue between rename and execute: slot 0 holds the
// oldest entry, the oldest operand-ready entry issues, and younger entries shift down.
module instr_issue_queue #(
  parameter int DEPTH     = 16,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 96
) (
  input  logic                         clk,
  input  logic                         rst_n,
  // Rename side
  input  logic                         in_wr,
  output logic                         in_ready,
  input  logic [TAG_W-1:0]             in_rs_phys,
  input  logic [TAG_W-1:0]             in_rt_phys,
  input  logic [TAG_W-1:0]             in_rw_phys,
  input  logic                         in_uses_rs,
  input  logic                         in_uses_rt,
  input  logic                         in_uses_rw,
  input  logic [PAYLOAD_W-1:0]         in_payload,
  input  logic [(2**TAG_W)-1:0]        busy_bits,
  // Writeback wakeup
  input  logic                         wb_valid,
  input  logic [TAG_W-1:0]             wb_tag,
  // Execute side
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [TAG_W-1:0]             iss_rs_phys,
  output logic [TAG_W-1:0]             iss_rt_phys,
  output logic [TAG_W-1:0]             iss_rw_phys,
  output logic                         iss_uses_rw,
  output logic [PAYLOAD_W-1:0]         iss_payload,
  // Control / status
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds its data stable while valid is high and ready is low.

  typedef struct packed {
    logic                 valid;
    logic                 rs_rdy;
    logic                 rt_rdy;
    logic [TAG_W-1:0]     rs;
    logic [TAG_W-1:0]     rt;
    logic [TAG_W-1:0]     rw;
    logic                 uses_rw;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t           q_q     [DEPTH];
  entry_t           q_d     [DEPTH];
  entry_t           woken   [DEPTH];
  entry_t           shifted [DEPTH];
  entry_t           new_entry;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] ins_pos;
  logic [DEPTH-1:0] elig;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             iss_fire;
  logic             ins_fire;

  assign in_ready = (count_q < CNT_W'(DEPTH));
  assign count    = count_q;
  assign iss_fire = sel_found & iss_ready;
  assign ins_fire = in_wr & in_ready & ~flush;

  // Eligibility and oldest-ready select, purely from registered state.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = q_q[i].valid & q_q[i].rs_rdy & q_q[i].rt_rdy;
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    iss_valid   = sel_found;
    iss_rs_phys = '0;
    iss_rt_phys = '0;
    iss_rw_phys = '0;
    iss_uses_rw = 1'b0;
    iss_payload = '0;
    if (sel_found) begin
      iss_rs_phys = q_q[sel_idx].rs;
      iss_rt_phys = q_q[sel_idx].rt;
      iss_rw_phys = q_q[sel_idx].rw;
      iss_uses_rw = q_q[sel_idx].uses_rw;
      iss_payload = q_q[sel_idx].payload;
    end
  end

  // Same-edge writeback wakeup applied before the collapse so shifted entries keep it.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = q_q[i];
      if (wb_valid && q_q[i].valid) begin
        if (wb_tag == q_q[i].rs) woken[i].rs_rdy = 1'b1;
        if (wb_tag == q_q[i].rt) woken[i].rt_rdy = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      shifted[i] = woken[i+1];
    end
    shifted[DEPTH-1] = '0;
  end

  // A source is ready at insert if unused, tag 0, not busy, or written back this very edge.
  always_comb begin
    new_entry         = '0;
    new_entry.valid   = 1'b1;
    new_entry.rs_rdy  = ~in_uses_rs | (in_rs_phys == '0) | ~busy_bits[in_rs_phys] |
                        (wb_valid & (wb_tag == in_rs_phys));
    new_entry.rt_rdy  = ~in_uses_rt | (in_rt_phys == '0) | ~busy_bits[in_rt_phys] |
                        (wb_valid & (wb_tag == in_rt_phys));
    new_entry.rs      = in_rs_phys;
    new_entry.rt      = in_rt_phys;
    new_entry.rw      = in_rw_phys;
    new_entry.uses_rw = in_uses_rw;
    new_entry.payload = in_payload;
  end

  assign ins_pos = iss_fire ? (count_q - CNT_W'(1)) : count_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      q_d[i] = woken[i];
      if (iss_fire && (IDX_W'(i) >= sel_idx)) begin
        q_d[i] = shifted[i];
      end
      if (ins_fire && (CNT_W'(i) == ins_pos)) begin
        q_d[i] = new_entry;
      end
      if (flush) begin
        q_d[i] = '0;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({ins_fire, iss_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        q_q[i] <= q_d[i];
      end
    end
  end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Bench for instr_issue_queue: directed scenarios plus random traffic, checked every
// cycle against a queue-based behavioural model of the issue queue.
module tb_instr_issue_queue;

  localparam int DEPTH = 16;
  localparam int TAG_W = 6;
  localparam int PW    = 96;
  localparam int CW    = $clog2(DEPTH+1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 in_wr, in_ready, in_uses_rs, in_uses_rt, in_uses_rw;
  logic [TAG_W-1:0]     in_rs_phys, in_rt_phys, in_rw_phys;
  logic [PW-1:0]        in_payload;
  logic [63:0]          busy_bits;
  logic                 wb_valid;
  logic [TAG_W-1:0]     wb_tag;
  logic                 iss_valid, iss_ready, iss_uses_rw;
  logic [TAG_W-1:0]     iss_rs_phys, iss_rt_phys, iss_rw_phys;
  logic [PW-1:0]        iss_payload;
  logic                 flush;
  logic [CW-1:0]        count;

  instr_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_wr(in_wr), .in_ready(in_ready),
    .in_rs_phys(in_rs_phys), .in_rt_phys(in_rt_phys), .in_rw_phys(in_rw_phys),
    .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt), .in_uses_rw(in_uses_rw),
    .in_payload(in_payload), .busy_bits(busy_bits),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs_phys(iss_rs_phys), .iss_rt_phys(iss_rt_phys), .iss_rw_phys(iss_rw_phys),
    .iss_uses_rw(iss_uses_rw), .iss_payload(iss_payload),
    .flush(flush), .count(count)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [TAG_W-1:0] rs, rt, rw;
    logic             uses_rw;
    logic             rs_rdy, rt_rdy;
    logic [PW-1:0]    payload;
  } m_ent_t;

  m_ent_t mq[$];
  logic [PW-1:0] exp_q[$];  // payloads in the order the model issues them

  function automatic int m_sel();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].rs_rdy && mq[i].rt_rdy) return i;
    return -1;
  endfunction

  function automatic logic src_ready(input logic uses, input logic [TAG_W-1:0] t);
    return !uses || (t == 0) || !busy_bits[t] || (wb_valid && wb_tag == t);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int     s;
    m_ent_t n;
    if (!rst_n || flush) begin
      mq.delete();
    end else begin
      s = m_sel();
      n.rs = in_rs_phys; n.rt = in_rt_phys; n.rw = in_rw_phys;
      n.uses_rw = in_uses_rw; n.payload = in_payload;
      n.rs_rdy = src_ready(in_uses_rs, in_rs_phys);
      n.rt_rdy = src_ready(in_uses_rt, in_rt_phys);
      if (wb_valid)
        foreach (mq[i]) begin
          if (mq[i].rs == wb_tag) mq[i].rs_rdy = 1'b1;
          if (mq[i].rt == wb_tag) mq[i].rt_rdy = 1'b1;
        end
      // in_ready is judged on occupancy before this edge's issue
      if (in_wr && mq.size() < DEPTH) begin
        if (s >= 0 && iss_ready) begin
          exp_q.push_back(mq[s].payload);
          mq.delete(s);
        end
        mq.push_back(n);
      end else if (s >= 0 && iss_ready) begin
        exp_q.push_back(mq[s].payload);
        mq.delete(s);
      end
    end
  end

  // One compare process: outputs are a function of registered state only.
  always @(negedge clk) begin : compare
    int s;
    if (rst_n) begin
      s = m_sel();
      check("count",     128'(count),     128'(mq.size()));
      check("in_ready",  128'(in_ready),  128'(mq.size() < DEPTH));
      check("iss_valid", 128'(iss_valid), 128'(s >= 0));
      if (s >= 0) begin
        check("iss_tags", 128'({iss_rs_phys, iss_rt_phys, iss_rw_phys, iss_uses_rw}),
              128'({mq[s].rs, mq[s].rt, mq[s].rw, mq[s].uses_rw}));
        check("iss_payload", 128'(iss_payload), 128'(mq[s].payload));
      end else begin
        check("iss_idle_data", 128'({iss_rs_phys, iss_rt_phys, iss_rw_phys, iss_uses_rw, iss_payload}), 128'(0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_wr = 0; in_rs_phys = 0; in_rt_phys = 0; in_rw_phys = 0;
    in_uses_rs = 0; in_uses_rt = 0; in_uses_rw = 0; in_payload = '0;
    wb_valid = 0; wb_tag = 0; iss_ready = 0; flush = 0;
  endtask

  task automatic ins(input logic [TAG_W-1:0] rs, input logic [TAG_W-1:0] rt,
                     input logic urs, input logic urt, input logic [PW-1:0] pl);
    in_wr = 1; in_rs_phys = rs; in_rt_phys = rt; in_rw_phys = rs ^ rt;
    in_uses_rs = urs; in_uses_rt = urt; in_uses_rw = 1; in_payload = pl;
  endtask

  task automatic do_flush();
    idle(); flush = 1; tick(); flush = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    busy_bits = '0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    check("rst_count",     128'(count), 128'(0));
    check("rst_in_ready",  128'(in_ready), 128'(1));
    check("rst_iss_valid", 128'(iss_valid), 128'(0));
    check("rst_iss_data",  128'(iss_payload), 128'(0));

    // 1: basic insert then issue
    ins(5, 6, 1, 1, 96'hA1); tick(); idle();
    check("t1_valid", 128'(iss_valid), 128'(1));
    check("t1_tags",  128'({iss_rs_phys, iss_rt_phys}), 128'({6'd5, 6'd6}));
    check("t1_count", 128'(count), 128'(1));
    iss_ready = 1; tick(); idle();
    check("t1_count0", 128'(count), 128'(0));
    check("t1_empty",  128'(iss_valid), 128'(0));

    // 2: younger ready entry bypasses an older busy one
    busy_bits = 64'h1 << 9;
    ins(9, 0, 1, 0, 96'hA); tick();
    ins(3, 0, 1, 0, 96'hB); tick(); idle();
    check("t2_b_first", 128'(iss_rs_phys), 128'(3));
    iss_ready = 1; tick(); idle();
    check("t2_a_wait", 128'(iss_valid), 128'(0));
    wb_valid = 1; wb_tag = 9; tick(); idle();
    check("t2_a_woken", 128'({iss_valid, iss_rs_phys}), 128'({1'b1, 6'd9}));
    iss_ready = 1; tick(); idle();
    busy_bits = '0;

    // 3: full queue
    busy_bits = '1;
    for (int i = 0; i < DEPTH; i++) begin
      ins(TAG_W'(10 + i), 0, 1, 0, PW'(100 + i)); tick();
    end
    check("t3_full", 128'({in_ready, count}), 128'({1'b0, 5'd16}));
    ins(60, 0, 1, 0, 96'hDEAD); tick(); idle();
    check("t3_drop", 128'(count), 128'(16));
    check("t3_none", 128'(iss_valid), 128'(0));
    wb_valid = 1; wb_tag = 17; tick(); idle();
    check("t3_slot7", 128'({iss_valid, iss_rs_phys, iss_payload}), 128'({1'b1, 6'd17, 96'd107}));
    check("t3_still_full", 128'(in_ready), 128'(0));
    iss_ready = 1; tick(); idle();
    check("t3_credit", 128'({in_ready, count}), 128'({1'b1, 5'd15}));
    do_flush();
    busy_bits = '0;

    // 4: insert + issue + wakeup of the new entry in one edge
    busy_bits = (64'h1 << 40) | (64'h1 << 50);
    ins(1, 0, 1, 0, 96'h11); tick();
    ins(40, 0, 1, 0, 96'h22); tick();
    ins(50, 0, 1, 0, 96'h33); iss_ready = 1; wb_valid = 1; wb_tag = 50; tick(); idle();
    check("t4_count", 128'(count), 128'(2));
    check("t4_new_rdy", 128'({iss_valid, iss_rs_phys}), 128'({1'b1, 6'd50}));
    wb_valid = 1; wb_tag = 40; tick(); idle();
    check("t4_order", 128'(iss_payload), 128'(96'h22));
    do_flush();
    busy_bits = '0;

    // 5: stall stability, then flush with a colliding insert
    for (int i = 0; i < 5; i++) begin
      ins(TAG_W'(i + 1), TAG_W'(i + 2), 1, 1, PW'(96'hC0 + i)); tick();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_stable", 128'({iss_valid, iss_rs_phys, iss_payload}), 128'({1'b1, 6'd1, 96'hC0}));
    end
    ins(7, 7, 1, 1, 96'hEE); iss_ready = 1; flush = 1; tick(); idle();
    check("t5_flush", 128'({count, iss_valid}), 128'({5'd0, 1'b0}));

    // 6: asynchronous reset mid-stream
    busy_bits = '1;
    for (int i = 0; i < 10; i++) begin
      ins(TAG_W'(20 + i), 0, 1, 0, PW'(i)); tick();
    end
    idle();
    check("t6_pre", 128'(count), 128'(10));
    @(negedge clk); #2 rst_n = 0; #1;
    check("t6_async", 128'({count, iss_valid, in_ready}), 128'({5'd0, 1'b0, 1'b1}));
    @(posedge clk); #1 rst_n = 1;
    busy_bits = '0;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      in_wr      = ($urandom_range(0, 9) < 7);
      in_rs_phys = TAG_W'($urandom_range(0, 63));
      in_rt_phys = TAG_W'($urandom_range(0, 63));
      in_rw_phys = TAG_W'($urandom_range(0, 63));
      in_uses_rs = $urandom_range(0, 1);
      in_uses_rt = $urandom_range(0, 1);
      in_uses_rw = $urandom_range(0, 1);
      in_payload = {$urandom, $urandom, $urandom};
      busy_bits  = {$urandom, $urandom} & {$urandom, $urandom};
      wb_valid   = $urandom_range(0, 1);
      wb_tag     = TAG_W'($urandom_range(0, 63));
      iss_ready  = ($urandom_range(0, 9) < (c < 1500 ? 4 : 7));
      flush      = ($urandom_range(0, 99) < 2);
      tick();
    end
    idle();
    tick();
    check("exp_q_nonempty", 128'(exp_q.size() > 100), 128'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
